// File: rtl/scmp_microcode_seq.sv
// Micro-PC sequencer for the SC/MP microcode engine: opcode-class dispatch,
// conditional branch and a CALL/RET micro-subroutine stack.
module scmp_microcode_seq #(
    parameter int unsigned UPC_W       = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [7:0]  LBL_FETCH   = 8'h00,
    parameter logic [7:0]  LBL_LD      = 8'h10,
    parameter logic [7:0]  LBL_ST      = 8'h20,
    parameter logic [7:0]  LBL_ILD     = 8'h30,
    parameter logic [7:0]  LBL_DLD     = 8'h40,
    parameter logic [7:0]  LBL_JMP     = 8'h50
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 stall,
    input  logic [7:0]                           op,
    input  logic [2:0]                           seq_op,
    input  logic [UPC_W-1:0]                     seq_tgt,
    input  logic                                 cond,
    output logic [UPC_W-1:0]                     upc,
    output logic [7:0]                           op_q,
    output logic [2:0]                           op_cls,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stk_level,
    output logic                                 stk_ovf,
    output logic                                 stk_unf
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << IDX_W;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'b000,
        SEQ_JUMP     = 3'b001,
        SEQ_BRC      = 3'b010,
        SEQ_CALL     = 3'b011,
        SEQ_RET      = 3'b100,
        SEQ_DISPATCH = 3'b101,
        SEQ_FETCH    = 3'b110
    } seq_cmd_e;

    localparam logic [2:0] CLS_FETCH = 3'd0;
    localparam logic [2:0] CLS_LD    = 3'd1;
    localparam logic [2:0] CLS_ST    = 3'd2;
    localparam logic [2:0] CLS_ILD   = 3'd3;
    localparam logic [2:0] CLS_DLD   = 3'd4;
    localparam logic [2:0] CLS_JMP   = 3'd5;

    logic [UPC_W-1:0] stk [SLOTS];

    logic [UPC_W-1:0] upc_inc_c;
    logic [UPC_W-1:0] stk_top_c;
    logic [UPC_W-1:0] upc_d;
    logic [7:0]       op_q_d;
    logic [2:0]       op_cls_d;
    logic [LVL_W-1:0] level_d;
    logic             ovf_d;
    logic             unf_d;
    logic             push_c;
    logic             stk_full_c;
    logic             stk_empty_c;

    // Priority-ordered opcode class decode; earlier rules shadow later ones.
    function automatic logic [2:0] op_class(input logic [7:0] o);
        if (o[7:3] == 5'b11001 && o[2:0] != 3'b100) return CLS_ST;
        if (o[7:6] == 2'b11)                        return CLS_LD;
        if (o[7:6] == 2'b01 && o[2:0] == 3'b000)    return CLS_LD;
        if (o[7:2] == 6'b101010)                    return CLS_ILD;
        if (o[7:2] == 6'b101110)                    return CLS_DLD;
        if (o[7:4] == 4'b1001)                      return CLS_JMP;
        return CLS_FETCH;
    endfunction

    function automatic logic [UPC_W-1:0] entry_addr(input logic [2:0] cls);
        case (cls)
            CLS_LD:  return UPC_W'(LBL_LD);
            CLS_ST:  return UPC_W'(LBL_ST);
            CLS_ILD: return UPC_W'(LBL_ILD);
            CLS_DLD: return UPC_W'(LBL_DLD);
            CLS_JMP: return UPC_W'(LBL_JMP);
            default: return UPC_W'(LBL_FETCH);
        endcase
    endfunction

    assign upc_inc_c   = upc + UPC_W'(1);
    assign stk_top_c   = stk[IDX_W'(stk_level - LVL_W'(1))];
    assign stk_full_c  = (stk_level == LVL_W'(STACK_DEPTH));
    assign stk_empty_c = (stk_level == '0);

    // Next-state decode of the sequencing command.
    always_comb begin
        upc_d    = upc_inc_c;
        op_q_d   = op_q;
        op_cls_d = op_cls;
        level_d  = stk_level;
        ovf_d    = stk_ovf;
        unf_d    = stk_unf;
        push_c   = 1'b0;
        case (seq_op)
            SEQ_JUMP: upc_d = seq_tgt;
            SEQ_BRC:  upc_d = cond ? seq_tgt : upc_inc_c;
            SEQ_CALL: begin
                upc_d = seq_tgt;
                if (stk_full_c) begin
                    ovf_d = 1'b1;
                end else begin
                    push_c  = 1'b1;
                    level_d = stk_level + LVL_W'(1);
                end
            end
            SEQ_RET: begin
                if (stk_empty_c) begin
                    upc_d = UPC_W'(LBL_FETCH);
                    unf_d = 1'b1;
                end else begin
                    upc_d   = stk_top_c;
                    level_d = stk_level - LVL_W'(1);
                end
            end
            SEQ_DISPATCH: begin
                op_q_d   = op;
                op_cls_d = op_class(op);
                upc_d    = entry_addr(op_class(op));
                level_d  = '0;
            end
            SEQ_FETCH: begin
                upc_d   = UPC_W'(LBL_FETCH);
                level_d = '0;
            end
            default: upc_d = upc_inc_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc       <= UPC_W'(LBL_FETCH);
            op_q      <= '0;
            op_cls    <= '0;
            stk_level <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
        end else if (!stall) begin
            upc       <= upc_d;
            op_q      <= op_q_d;
            op_cls    <= op_cls_d;
            stk_level <= level_d;
            stk_ovf   <= ovf_d;
            stk_unf   <= unf_d;
        end
    end

    // Stack storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !stall && push_c) begin
            stk[IDX_W'(stk_level)] <= upc_inc_c;
        end
    end

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Self-checking bench for scmp_microcode_seq: directed scenarios plus random
// command streams compared against a queue-based reference model.
module tb_scmp_microcode_seq;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [7:0] op;
    logic [2:0] seq_op;
    logic [7:0] seq_tgt;
    logic       cond;
    logic [7:0] upc;
    logic [7:0] op_q;
    logic [2:0] op_cls;
    logic [2:0] stk_level;
    logic       stk_ovf;
    logic       stk_unf;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0] m_upc;
    logic [7:0] m_opq;
    logic [2:0] m_cls;
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_stk[$];

    scmp_microcode_seq #(.UPC_W(8), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .op(op), .seq_op(seq_op),
        .seq_tgt(seq_tgt), .cond(cond), .upc(upc), .op_q(op_q), .op_cls(op_cls),
        .stk_level(stk_level), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [7:0] o);
        logic [2:0] c;
        c = 3'd0;
        if      (o >= 8'hC8 && o <= 8'hCF && o != 8'hCC) c = 3'd2;
        else if (o >= 8'hC0)                             c = 3'd1;
        else if (o >= 8'h40 && o < 8'h80 && o % 8 == 0)  c = 3'd1;
        else if (o >= 8'hA8 && o <= 8'hAB)               c = 3'd3;
        else if (o >= 8'hB8 && o <= 8'hBB)               c = 3'd4;
        else if (o >= 8'h90 && o <= 8'h9F)               c = 3'd5;
        return c;
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [2:0] so,
                              input logic [7:0] t, input bit c, input logic [7:0] o);
        if (r) begin
            m_upc = 8'h00; m_opq = 8'h00; m_cls = 3'd0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (!s) begin
            case (so)
                3'd1: m_upc = t;
                3'd2: m_upc = c ? t : m_upc + 8'd1;
                3'd3: begin
                    if (m_stk.size() == DEPTH) m_ovf = 1;
                    else m_stk.push_back(m_upc + 8'd1);
                    m_upc = t;
                end
                3'd4: begin
                    if (m_stk.size() == 0) begin m_upc = 8'h00; m_unf = 1; end
                    else m_upc = m_stk.pop_back();
                end
                3'd5: begin
                    m_opq = o; m_cls = ref_class(o);
                    m_upc = 8'(m_cls * 16);
                    m_stk.delete();
                end
                3'd6: begin m_upc = 8'h00; m_stk.delete(); end
                default: m_upc = m_upc + 8'd1;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit s, input logic [2:0] so,
                       input logic [7:0] t, input bit c, input logic [7:0] o);
        rst = r; stall = s; seq_op = so; seq_tgt = t; cond = c; op = o;
        @(posedge clk);
        model_step(r, s, so, t, c, o);
        #1;
        check_eq("upc", 32'(upc), 32'(m_upc));
        check_eq("op_q", 32'(op_q), 32'(m_opq));
        check_eq("op_cls", 32'(op_cls), 32'(m_cls));
        check_eq("stk_level", 32'(stk_level), 32'(m_stk.size()));
        check_eq("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
        check_eq("stk_unf", 32'(stk_unf), 32'(m_unf));
    endtask

    logic [7:0] disp_ops [7] = '{8'hC8, 8'hCC, 8'h40, 8'hA8, 8'hB8, 8'h90, 8'h00};
    logic [7:0] disp_exp [7] = '{8'h20, 8'h10, 8'h10, 8'h30, 8'h40, 8'h50, 8'h00};
    logic [7:0] ret_exp  [4] = '{8'h73, 8'h72, 8'h71, 8'h61};

    initial begin
        m_upc = 0; m_opq = 0; m_cls = 0; m_ovf = 0; m_unf = 0;

        // Reset and NEXT, including wrap
        cyc(1, 0, 3'd1, 8'h55, 0, 8'h00);
        check_eq("rst_upc", 32'(upc), 32'h00);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 3'd0, 8'h00, 0, 8'h00);
            check_eq("next_upc", 32'(upc), 32'(i));
        end
        cyc(0, 0, 3'd1, 8'hFF, 0, 8'h00);
        cyc(0, 0, 3'd0, 8'h00, 0, 8'h00);
        check_eq("wrap_upc", 32'(upc), 32'h00);

        // Dispatch of each opcode class
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 3'd5, 8'h00, 0, disp_ops[i]);
            check_eq("disp_upc", 32'(upc), 32'(disp_exp[i]));
            if (i == 0) check_eq("disp_cls_st", 32'(op_cls), 32'd2);
        end

        // Single CALL/RET
        cyc(0, 0, 3'd1, 8'h12, 0, 8'h00);
        cyc(0, 0, 3'd3, 8'h80, 0, 8'h00);
        check_eq("call_upc", 32'(upc), 32'h80);
        check_eq("call_lvl", 32'(stk_level), 32'd1);
        cyc(0, 0, 3'd4, 8'h00, 0, 8'h00);
        check_eq("ret_upc", 32'(upc), 32'h13);
        check_eq("ret_lvl", 32'(stk_level), 32'd0);

        // Overflow and underflow
        cyc(0, 0, 3'd1, 8'h60, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 3'd3, 8'(8'h70 + i), 0, 8'h00);
        check_eq("ovf_lvl", 32'(stk_level), 32'd4);
        check_eq("ovf_flag", 32'(stk_ovf), 32'd1);
        check_eq("ovf_upc", 32'(upc), 32'h74);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'd4, 8'h00, 0, 8'h00);
            check_eq("lifo_upc", 32'(upc), 32'(ret_exp[i]));
        end
        cyc(0, 0, 3'd4, 8'h00, 0, 8'h00);
        check_eq("unf_upc", 32'(upc), 32'h00);
        check_eq("unf_flag", 32'(stk_unf), 32'd1);

        // Stall hold and BRC
        cyc(0, 0, 3'd1, 8'h30, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3'd1, 8'h99, 1, 8'hC8);
            check_eq("stall_upc", 32'(upc), 32'h30);
        end
        cyc(0, 0, 3'd2, 8'h44, 0, 8'h00);
        check_eq("brc_nt", 32'(upc), 32'h31);
        cyc(0, 0, 3'd2, 8'h44, 1, 8'h00);
        check_eq("brc_t", 32'(upc), 32'h44);

        // Reset mid-subroutine overrides stall
        cyc(0, 0, 3'd3, 8'h20, 0, 8'h00);
        cyc(0, 0, 3'd3, 8'h28, 0, 8'h00);
        check_eq("pre_rst_lvl", 32'(stk_level), 32'd2);
        cyc(1, 1, 3'd0, 8'h00, 0, 8'h00);
        check_eq("mid_rst_upc", 32'(upc), 32'h00);
        check_eq("mid_rst_lvl", 32'(stk_level), 32'd0);
        check_eq("mid_rst_flags", 32'({stk_ovf, stk_unf}), 32'd0);

        // Random command streams against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] o;
            logic [2:0] so;
            o  = ($urandom_range(0, 1) == 0) ? disp_ops[$urandom_range(0, 6)] : 8'($urandom);
            so = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), so,
                8'($urandom), 1'($urandom), o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
